// File: rtl/ed25519_point_encoder.sv
// ed25519_point_encoder
//   Turns the 8-beat affine result stream (x as 4 words, then y as 4 words,
//   MSB-first) into the 32-byte compressed encoding {x[0], y[254:0]}. The
//   encoding leaves as a 4-beat stream with a per-frame non-canonical flag.
//   There is one frame buffer, so the input and output phases never overlap.
// Ports:
//   i_clk        clock
//   i_rst        synchronous reset, active-high
//   i_in_valid   upstream word valid
//   i_in_data    upstream 64-bit word
//   o_in_ready   block can accept a word (registered)
//   o_out_valid  output word valid (registered)
//   o_out_data   encoded 64-bit word, MSB-first (registered)
//   i_out_ready  downstream accepts word
//   o_out_last   high with the 4th output word (registered)
//   o_out_err    frame was non-canonical; held for the whole output frame
module ed25519_point_encoder #(
  parameter int IN_BEATS  = 8,
  parameter int OUT_BEATS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_in_valid,
  input  logic [63:0] i_in_data,
  output logic        o_in_ready,
  output logic        o_out_valid,
  output logic [63:0] o_out_data,
  input  logic        i_out_ready,
  output logic        o_out_last,
  output logic        o_out_err
);

  localparam logic [1:0] S_READ  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_OUT   = 2'd2;

  // Field prime p = 2^255 - 19, held at 256 bits so 255-bit fields compare unsigned.
  localparam logic [255:0] P_MOD =
    256'h7FFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFED;

  // True when a 255-bit field element is not reduced modulo p.
  function automatic logic f_ge_p(input logic [254:0] i_v);
    return ({1'b0, i_v} >= P_MOD);
  endfunction

  logic [1:0]   r_state;
  logic [1:0]   w_state_nxt;
  logic [2:0]   r_cnt;
  logic [2:0]   w_cnt_nxt;
  logic [511:0] r_buf;
  logic [255:0] r_enc;
  logic         r_in_ready;
  logic         r_out_valid;
  logic [63:0]  r_out_data;
  logic         r_out_last;
  logic         r_out_err;

  logic         w_out_valid_nxt;
  logic [63:0]  w_out_data_nxt;
  logic         w_out_last_nxt;
  logic         w_out_err_nxt;

  logic [254:0] w_x;
  logic [254:0] w_y;
  logic         w_err;
  logic [255:0] w_enc;
  logic         w_in_fire;
  logic         w_out_fire;
  logic         w_in_final;
  logic         w_out_final;
  logic [1:0]   w_ocnt_nxt;

  assign w_x   = r_buf[510:256];
  assign w_y   = r_buf[254:0];
  // Either pad bit set also makes the frame non-canonical.
  assign w_err = f_ge_p(w_x) | f_ge_p(w_y) | r_buf[511] | r_buf[255];
  assign w_enc = {w_x[0], w_y};

  assign w_in_fire   = r_in_ready & i_in_valid & (r_state == S_READ);
  assign w_out_fire  = r_out_valid & i_out_ready & (r_state == S_OUT);
  assign w_in_final  = (r_cnt == 3'(IN_BEATS - 1));
  assign w_out_final = (r_cnt[1:0] == 2'(OUT_BEATS - 1));
  assign w_ocnt_nxt  = r_cnt[1:0] + 2'd1;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_READ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_READ: begin
        if (w_in_fire && w_in_final) w_state_nxt = S_CHECK;
        else                         w_state_nxt = S_READ;
      end
      S_CHECK: w_state_nxt = S_OUT;
      S_OUT: begin
        if (w_out_fire && w_out_final) w_state_nxt = S_READ;
        else                           w_state_nxt = S_OUT;
      end
      default: w_state_nxt = S_READ;
    endcase
  end

  // Next values of the counter and of the registered outputs.
  always_comb begin
    w_cnt_nxt       = r_cnt;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;
    w_out_err_nxt   = r_out_err;
    case (r_state)
      S_READ: begin
        if (w_in_fire) begin
          if (w_in_final) w_cnt_nxt = 3'd0;
          else            w_cnt_nxt = r_cnt + 3'd1;
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_CHECK: begin
        // First output word is loaded straight from the check result.
        w_cnt_nxt       = 3'd0;
        w_out_valid_nxt = 1'b1;
        w_out_data_nxt  = w_enc[255:192];
        w_out_last_nxt  = 1'b0;
        w_out_err_nxt   = w_err;
      end
      S_OUT: begin
        if (w_out_fire && w_out_final) begin
          w_cnt_nxt       = 3'd0;
          w_out_valid_nxt = 1'b0;
          w_out_data_nxt  = 64'd0;
          w_out_last_nxt  = 1'b0;
          w_out_err_nxt   = 1'b0;
        end else if (w_out_fire) begin
          // Word k sits at E[64*(3-k) +: 64]; 3-k is ~k for a 2-bit index.
          w_cnt_nxt      = {1'b0, w_ocnt_nxt};
          w_out_data_nxt = r_enc[{~w_ocnt_nxt, 6'd0} +: 64];
          w_out_last_nxt = (w_ocnt_nxt == 2'(OUT_BEATS - 1));
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: w_cnt_nxt = 3'd0;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= 3'd0;
      r_buf       <= 512'd0;
      r_enc       <= 256'd0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 64'd0;
      r_out_last  <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_in_ready  <= (w_state_nxt == S_READ);
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
      r_out_err   <= w_out_err_nxt;
      // Word k lands at buffer[64*(7-k) +: 64]; 7-k is ~k for a 3-bit index.
      if (w_in_fire) r_buf[{~r_cnt, 6'd0} +: 64] <= i_in_data;
      if (r_state == S_CHECK) r_enc <= w_enc;
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_last  = r_out_last;
  assign o_out_err   = r_out_err;

endmodule

// File: tb/tb_ed25519_point_encoder.sv
// Self-checking bench for ed25519_point_encoder: a reference model computes
// the compressed encoding and error flag, and a compare process checks every
// output cycle against a queue of expected words.
module tb_ed25519_point_encoder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_in_valid = 1'b0;
  logic [63:0] i_in_data = 64'd0;
  logic        i_out_ready = 1'b0;
  logic        o_in_ready;
  logic        o_out_valid;
  logic [63:0] o_out_data;
  logic        o_out_last;
  logic        o_out_err;

  ed25519_point_encoder dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_in_valid (i_in_valid),
    .i_in_data  (i_in_data),
    .o_in_ready (o_in_ready),
    .o_out_valid(o_out_valid),
    .o_out_data (o_out_data),
    .i_out_ready(i_out_ready),
    .o_out_last (o_out_last),
    .o_out_err  (o_out_err)
  );

  always #5 i_clk = ~i_clk;

  localparam logic [255:0] P256 =
    256'h7FFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFED;
  localparam logic [255:0] BASE_X =
    256'h216936D3CD6E53FE_C0A4E231FDD6DC5C_692CC7609525A7B2_C9562D608F25D51A;
  localparam logic [255:0] BASE_Y =
    256'h6666666666666666_6666666666666666_6666666666666666_6666666666666658;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   rmode = 0;   // 0: ready high, 1: pattern 1-0-0-1, 2: random, 3: ready low
  int   rphase = 0;

  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_frame(input logic px, input logic [255:0] x,
                                            input logic py, input logic [255:0] y);
    return {px, x[254:0], py, y[254:0]};
  endfunction

  // Reference: returns {err, encoding} for a 512-bit frame.
  function automatic logic [256:0] model(input logic [511:0] f);
    logic [255:0] xv;
    logic [255:0] yv;
    logic         e;
    xv = {1'b0, f[510:256]};
    yv = {1'b0, f[254:0]};
    e  = (xv >= P256) || (yv >= P256) || f[511] || f[255];
    return {e, xv[0], yv[254:0]};
  endfunction

  task automatic push_expected(input logic [511:0] f);
    logic [256:0] m;
    exp_t         x;
    m = model(f);
    for (int i = 0; i < 4; i++) begin
      x.data = m[255 - 64*i -: 64];
      x.last = (i == 3);
      x.err  = m[256];
      q.push_back(x);
    end
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_in_ready"},  256'(o_in_ready),  256'd0);
    check({nm, "_out_valid"}, 256'(o_out_valid), 256'd0);
    check({nm, "_out_data"},  256'(o_out_data),  256'd0);
    check({nm, "_out_last"},  256'(o_out_last),  256'd0);
    check({nm, "_out_err"},   256'(o_out_err),   256'd0);
  endtask

  // Drives nw words of frame f with bubble_pct% idle cycles; a full frame also
  // checks the two-cycle turnaround and queues the expected output.
  task automatic send_frame(input logic [511:0] f, input int bubble_pct, input int nw);
    int k = 0;
    int guard = 0;
    while (k < nw && guard < 2000) begin
      @(posedge i_clk); #1;
      guard++;
      if ($urandom_range(99) < bubble_pct) begin
        i_in_valid = 1'b0;
        i_in_data  = {$urandom, $urandom};
      end else begin
        i_in_valid = 1'b1;
        i_in_data  = f[511 - 64*k -: 64];
      end
      if (i_in_valid && o_in_ready) k++;
    end
    if (k < nw) begin
      check("in_timeout", 256'(k), 256'(nw));
    end else if (nw == 8) begin
      @(posedge i_clk); #1;
      // Garbage offered while the block is busy must be ignored.
      i_in_valid = 1'b1;
      i_in_data  = {$urandom, $urandom};
      push_expected(f);
      check("lat_in_ready_t1", 256'(o_in_ready), 256'd0);
      check("lat_valid_t1", 256'(o_out_valid), 256'd0);
      @(posedge i_clk); #1;
      check("lat_valid_t2", 256'(o_out_valid), 256'd1);
      i_in_valid = 1'b0;
    end else begin
      i_in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int guard = 0;
    while (q.size() > 0 && guard < 2000) begin
      @(posedge i_clk); #1;
      guard++;
    end
    check("drain_timeout", 256'(q.size()), 256'd0);
  endtask

  task automatic pulse_reset(input string nm);
    @(posedge i_clk); #1;
    i_in_valid = 1'b0;
    i_rst = 1'b1;
    q.delete();
    @(posedge i_clk); #1;
    check_idle(nm);
    i_rst = 1'b0;
  endtask

  // Compare process: checks outputs every cycle and chooses the ready for the next edge.
  always @(negedge i_clk) begin
    logic r;
    exp_t e;
    if (i_rst) begin
      i_out_ready = 1'b0;
    end else begin
      if (q.size() > 0) check("busy_in_ready", 256'(o_in_ready), 256'd0);
      if (o_out_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 256'(o_out_valid), 256'd0);
        end else begin
          e = q[0];
          check("out_data", 256'(o_out_data), 256'(e.data));
          check("out_last", 256'(o_out_last), 256'(e.last));
          check("out_err",  256'(o_out_err),  256'(e.err));
        end
      end else begin
        check("idle_last", 256'(o_out_last), 256'd0);
        check("idle_err",  256'(o_out_err),  256'd0);
      end
      case (rmode)
        0: r = 1'b1;
        1: r = (rphase % 4 == 0) || (rphase % 4 == 3);
        2: r = ($urandom_range(1) == 1);
        default: r = 1'b0;
      endcase
      if (o_out_valid) rphase++;
      i_out_ready = r;
      if (o_out_valid && r && q.size() > 0) void'(q.pop_front());
    end
  end

  initial begin
    logic [511:0] f_base;
    logic [511:0] f_one;
    logic [511:0] f_yp;
    logic [511:0] f_pad;
    logic [511:0] f;
    logic [256:0] m;
    logic [255:0] xr;
    logic [255:0] yr;
    logic [255:0] t;

    f_base = mk_frame(1'b0, BASE_X, 1'b0, BASE_Y);
    f_one  = mk_frame(1'b0, 256'd1, 1'b0, 256'd1);
    f_yp   = mk_frame(1'b0, 256'd0, 1'b0, P256);
    f_pad  = mk_frame(1'b0, 256'd1, 1'b1, 256'd1);

    // Hand-computed encodings pin the model.
    m = model(f_base);
    check("pin_base_enc", m[255:0], BASE_Y);
    check("pin_base_err", 256'(m[256]), 256'd0);
    m = model(f_one);
    check("pin_one_enc", m[255:0],
          256'h8000000000000000_0000000000000000_0000000000000000_0000000000000001);
    check("pin_one_err", 256'(m[256]), 256'd0);
    m = model(f_yp);
    check("pin_yp_enc", m[255:0],
          256'h7FFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFFF_FFFFFFFFFFFFFFED);
    check("pin_yp_err", 256'(m[256]), 256'd1);
    m = model(f_pad);
    check("pin_pad_err", 256'(m[256]), 256'd1);

    repeat (3) @(posedge i_clk);
    #1;
    check_idle("reset");
    i_rst = 1'b0;

    // Base point and x=1,y=1 back to back with full valid/ready.
    rmode = 0;
    send_frame(f_base, 0, 8);
    send_frame(f_one, 0, 8);
    wait_drain();

    // Non-canonical frames under 1-0-0-1 ready.
    rmode = 1;
    rphase = 0;
    send_frame(f_yp, 0, 8);
    send_frame(f_pad, 0, 8);
    wait_drain();

    // Input bubbles must not change the result.
    rmode = 0;
    send_frame(f_base, 40, 8);
    wait_drain();

    // Reset after 5 input words, then a fresh frame.
    send_frame(f_one, 0, 5);
    pulse_reset("rst_mid_in");
    send_frame(f_one, 0, 8);
    wait_drain();

    // Reset while an output word is stalled.
    rmode = 3;
    send_frame(f_base, 0, 8);
    pulse_reset("rst_mid_out");
    rmode = 0;
    send_frame(f_one, 20, 8);
    wait_drain();

    // Random frames, including values around p and pad bits.
    rmode = 2;
    for (int n = 0; n < 24; n++) begin
      for (int i = 0; i < 8; i++) begin
        xr = {xr[223:0], 32'($urandom)};
        yr = {yr[223:0], 32'($urandom)};
      end
      t = P256 + 256'($urandom_range(0, 18));
      case ($urandom_range(4))
        0: xr = t;
        1: yr = t;
        2: yr = P256 - 256'd1;
        default: ;
      endcase
      f = mk_frame($urandom_range(7) == 0, xr, $urandom_range(7) == 0, yr);
      send_frame(f, 30, 8);
    end
    wait_drain();

    repeat (5) @(posedge i_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
